// File: rtl/sdc_buf_ctrl.sv
// Elastic buffer between the SD read path and a consumer, backed by an external
// dual-port block RAM (port A write, port B registered read) with a two-entry output stage.
module sdc_buf_ctrl #(
    parameter int unsigned DEPTH = 1041,
    parameter int unsigned AW    = 11,
    parameter int unsigned DW    = 64
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_vld,
    input  logic [DW-1:0] wr_data,
    output logic          wr_rdy,
    output logic          rd_vld,
    output logic [DW-1:0] rd_data,
    input  logic          rd_rdy,
    input  logic          flush,
    output logic [AW-1:0] level,
    output logic          full,
    output logic          empty,
    output logic          ovf_err,
    output logic [AW-1:0] ram_addr_a,
    output logic          ram_wr_a,
    output logic [DW-1:0] ram_din_a,
    output logic [AW-1:0] ram_addr_b,
    output logic          ram_wr_b,
    output logic [DW-1:0] ram_din_b,
    input  logic [DW-1:0] ram_dout_b
);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_level;
    logic          r_out_vld;
    logic [DW-1:0] r_out_data;
    logic          r_skid_vld;
    logic [DW-1:0] r_skid_data;
    logic          r_fetch_pend;
    logic          r_ovf;

    logic          w_full;
    logic          w_empty;
    logic          w_wr_rdy;
    logic          w_accept;
    logic          w_pop;
    logic          w_fetch;
    logic [1:0]    w_held;

    function automatic logic [AW-1:0] f_ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_full   = (r_level == AW'(DEPTH));
    assign w_empty  = (r_level == '0);
    assign w_wr_rdy = reset_n & ~w_full & ~flush;
    assign w_accept = wr_vld & w_wr_rdy;
    assign w_pop    = r_out_vld & rd_rdy;

    // Occupancy of the output stage including the word still inside the RAM read pipeline.
    assign w_held  = {1'b0, r_out_vld} + {1'b0, r_skid_vld} + {1'b0, r_fetch_pend};
    assign w_fetch = ~flush & ~w_empty & (w_pop ? (w_held < 2'd3) : (w_held < 2'd2));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= f_ptr_inc(r_wr_ptr);
            end
            if (w_fetch) begin
                r_rd_ptr <= f_ptr_inc(r_rd_ptr);
            end
            case ({w_accept, w_fetch})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Returning RAM data goes to the output register when it is free or being popped;
    // otherwise it parks in the skid. The fetch credit guarantees the skid is free then.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_vld    <= 1'b0;
            r_out_data   <= '0;
            r_skid_vld   <= 1'b0;
            r_skid_data  <= '0;
            r_fetch_pend <= 1'b0;
        end else if (flush) begin
            r_out_vld    <= 1'b0;
            r_out_data   <= '0;
            r_skid_vld   <= 1'b0;
            r_skid_data  <= '0;
            r_fetch_pend <= 1'b0;
        end else begin
            r_fetch_pend <= w_fetch;
            if (w_pop) begin
                if (r_skid_vld) begin
                    r_out_vld  <= 1'b1;
                    r_out_data <= r_skid_data;
                    r_skid_vld <= r_fetch_pend;
                    if (r_fetch_pend) begin
                        r_skid_data <= ram_dout_b;
                    end
                end else begin
                    r_out_vld <= r_fetch_pend;
                    if (r_fetch_pend) begin
                        r_out_data <= ram_dout_b;
                    end
                end
            end else if (r_fetch_pend) begin
                if (r_out_vld) begin
                    r_skid_vld  <= 1'b1;
                    r_skid_data <= ram_dout_b;
                end else begin
                    r_out_vld  <= 1'b1;
                    r_out_data <= ram_dout_b;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf <= 1'b0;
        end else if (flush) begin
            r_ovf <= 1'b0;
        end else if (wr_vld && !w_wr_rdy) begin
            r_ovf <= 1'b1;
        end
    end

    assign wr_rdy     = w_wr_rdy;
    assign rd_vld     = r_out_vld;
    assign rd_data    = r_out_data;
    assign level      = r_level;
    assign full       = w_full;
    assign empty      = w_empty;
    assign ovf_err    = r_ovf;

    assign ram_addr_a = r_wr_ptr;
    assign ram_wr_a   = w_accept;
    assign ram_din_a  = w_accept ? wr_data : '0;
    assign ram_addr_b = r_rd_ptr;
    assign ram_wr_b   = 1'b0;
    assign ram_din_b  = '0;

endmodule

// File: tb/tb_sdc_buf_ctrl.sv
// Directed bench for sdc_buf_ctrl: behavioural dual-port RAM plus hand-computed expectations
// for reset, latency, backpressure, fill/overflow, wrap, streaming, flush and async reset.
module tb_sdc_buf_ctrl;

    localparam int unsigned DEPTH = 1041;
    localparam int unsigned AW    = 11;
    localparam int unsigned DW    = 64;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          wr_vld;
    logic [DW-1:0] wr_data;
    logic          wr_rdy;
    logic          rd_vld;
    logic [DW-1:0] rd_data;
    logic          rd_rdy;
    logic          flush;
    logic [AW-1:0] level;
    logic          full;
    logic          empty;
    logic          ovf_err;
    logic [AW-1:0] ram_addr_a;
    logic          ram_wr_a;
    logic [DW-1:0] ram_din_a;
    logic [AW-1:0] ram_addr_b;
    logic          ram_wr_b;
    logic [DW-1:0] ram_din_b;
    logic [DW-1:0] ram_dout_b;

    logic [DW-1:0] mem [DEPTH];

    int n_pass;
    int n_fail;
    int n_total;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wr_a) mem[ram_addr_a] <= ram_din_a;
        ram_dout_b <= mem[ram_addr_b];
    end

    sdc_buf_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_vld     (wr_vld),
        .wr_data    (wr_data),
        .wr_rdy     (wr_rdy),
        .rd_vld     (rd_vld),
        .rd_data    (rd_data),
        .rd_rdy     (rd_rdy),
        .flush      (flush),
        .level      (level),
        .full       (full),
        .empty      (empty),
        .ovf_err    (ovf_err),
        .ram_addr_a (ram_addr_a),
        .ram_wr_a   (ram_wr_a),
        .ram_din_a  (ram_din_a),
        .ram_addr_b (ram_addr_b),
        .ram_wr_b   (ram_wr_b),
        .ram_din_b  (ram_din_b),
        .ram_dout_b (ram_dout_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int got;
        int stall;
        int nw;
        int nr;
        int wraps;
        int max_a;
        int e;
        logic [AW-1:0] last_a;
        logic [63:0] base;

        n_pass = 0; n_fail = 0; n_total = 0;
        reset_n = 1'b0; wr_vld = 1'b0; wr_data = '0; rd_rdy = 1'b0; flush = 1'b0;
        repeat (3) tick();

        // ---- reset values, with a write offered during reset
        wr_vld = 1'b1; wr_data = 64'h1234; #1;
        chk("rst_level",  64'(level),      64'd0);
        chk("rst_empty",  64'(empty),      64'd1);
        chk("rst_full",   64'(full),       64'd0);
        chk("rst_wr_rdy", 64'(wr_rdy),     64'd0);
        chk("rst_rd_vld", 64'(rd_vld),     64'd0);
        chk("rst_rd_data", rd_data,        64'd0);
        chk("rst_ram_wr_a", 64'(ram_wr_a), 64'd0);
        chk("rst_addr_a", 64'(ram_addr_a), 64'd0);
        chk("rst_addr_b", 64'(ram_addr_b), 64'd0);
        chk("rst_din_a",  ram_din_a,       64'd0);
        chk("rst_wr_b",   64'(ram_wr_b),   64'd0);
        chk("rst_din_b",  ram_din_b,       64'd0);
        tick();
        chk("rst_ovf",    64'(ovf_err),    64'd0);

        // ---- single word; first write accepted on the first edge after release
        reset_n = 1'b1; wr_data = 64'hA5A5_0000_0000_0001; rd_rdy = 1'b1; #1;
        chk("sw_wr_rdy",  64'(wr_rdy),     64'd1);
        chk("sw_wr_a",    64'(ram_wr_a),   64'd1);
        chk("sw_addr_a",  64'(ram_addr_a), 64'd0);
        chk("sw_din_a",   ram_din_a,       64'hA5A5_0000_0000_0001);
        tick(); wr_vld = 1'b0;
        chk("sw_c1_level", 64'(level),     64'd1);
        chk("sw_c1_empty", 64'(empty),     64'd0);
        chk("sw_c1_rd_vld", 64'(rd_vld),   64'd0);
        chk("sw_c1_addr_b", 64'(ram_addr_b), 64'd0);
        tick();
        chk("sw_c2_level", 64'(level),     64'd0);
        chk("sw_c2_rd_vld", 64'(rd_vld),   64'd0);
        tick();
        chk("sw_c3_rd_vld", 64'(rd_vld),   64'd1);
        chk("sw_c3_rd_data", rd_data,      64'hA5A5_0000_0000_0001);
        tick();
        chk("sw_c4_rd_vld", 64'(rd_vld),   64'd0);
        chk("sw_c4_empty", 64'(empty),     64'd1);

        // ---- backpressure: out reg + skid full, data held stable
        rd_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_vld = 1'b1; wr_data = 64'h100 + 64'(i);
            tick();
        end
        wr_vld = 1'b0;
        repeat (4) tick();
        chk("bp_rd_vld",  64'(rd_vld), 64'd1);
        chk("bp_rd_data", rd_data,     64'h100);
        chk("bp_level",   64'(level),  64'd2);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_vld",  64'(rd_vld), 64'd1);
            chk("bp_hold_data", rd_data,     64'h100);
        end
        rd_rdy = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            if (rd_vld) begin
                chk("bp_data", rd_data, 64'h100 + 64'(got));
                got++;
            end
            tick();
        end
        chk("bp_count",  64'(got),    64'd4);
        chk("bp_empty",  64'(empty),  64'd1);
        chk("bp_rd_vld_end", 64'(rd_vld), 64'd0);

        // ---- fill to full, then overflow
        rd_rdy = 1'b0; stall = 0;
        for (int i = 0; i < 1041; i++) begin
            wr_vld = 1'b1; wr_data = 64'(i); #1;
            if (!wr_rdy) stall++;
            tick();
        end
        wr_vld = 1'b0;
        chk("fill_refused", 64'(stall), 64'd0);
        repeat (4) tick();
        chk("fill_level_1039", 64'(level), 64'd1039);
        chk("fill_not_full",   64'(full),  64'd0);
        for (int i = 1041; i < 1043; i++) begin
            wr_vld = 1'b1; wr_data = 64'(i);
            tick();
        end
        wr_vld = 1'b0;
        chk("fill_level_full", 64'(level),  64'd1041);
        chk("fill_full",       64'(full),   64'd1);
        chk("fill_wr_rdy",     64'(wr_rdy), 64'd0);
        chk("fill_ovf_pre",    64'(ovf_err), 64'd0);
        wr_vld = 1'b1; wr_data = 64'hDEAD; #1;
        chk("ovf_no_write", 64'(ram_wr_a), 64'd0);
        tick(); wr_vld = 1'b0;
        chk("ovf_set",   64'(ovf_err), 64'd1);
        chk("ovf_level", 64'(level),   64'd1041);
        tick();
        chk("ovf_sticky", 64'(ovf_err), 64'd1);
        rd_rdy = 1'b1; got = 0;
        for (int c = 0; c < 1200 && got < 1043; c++) begin
            if (rd_vld) begin
                chk("fill_drain", rd_data, 64'(got));
                got++;
            end
            tick();
        end
        chk("fill_drain_count", 64'(got),    64'd1043);
        chk("fill_drain_empty", 64'(empty),  64'd1);
        chk("fill_drain_ovf",   64'(ovf_err), 64'd1);
        flush = 1'b1; #1;
        chk("flush_wr_rdy", 64'(wr_rdy), 64'd0);
        tick(); flush = 1'b0;
        chk("flush_ovf_clr", 64'(ovf_err), 64'd0);
        chk("flush_level",   64'(level),   64'd0);

        // ---- wrap: 1500 words, random consumer
        nw = 0; nr = 0; wraps = 0; max_a = 0; last_a = '0;
        for (int c = 0; c < 8000 && nr < 1500; c++) begin
            wr_vld = (nw < 1500); wr_data = 64'(nw); rd_rdy = 1'($urandom_range(0, 1)); #1;
            if (rd_vld && rd_rdy) begin
                chk("wrap_data", rd_data, 64'(nr));
                nr++;
            end
            if (wr_vld && wr_rdy) begin
                if (nw > 0 && ram_addr_a == '0 && last_a == AW'(DEPTH - 1)) wraps++;
                if (int'(ram_addr_a) > max_a) max_a = int'(ram_addr_a);
                last_a = ram_addr_a;
                nw++;
            end
            tick();
        end
        wr_vld = 1'b0; rd_rdy = 1'b0;
        chk("wrap_count", 64'(nr),    64'd1500);
        chk("wrap_seen",  64'(wraps), 64'd1);
        chk("wrap_max_a", 64'(max_a), 64'd1040);
        chk("wrap_ovf",   64'(ovf_err), 64'd0);

        // ---- streaming: level constant at 1, one pop per cycle after latency 3
        base = 64'h5000_0000;
        wr_vld = 1'b1; rd_rdy = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            wr_data = base + 64'(k);
            if (k >= 1) chk("stream_level", 64'(level), 64'd1);
            if (k >= 3) begin
                chk("stream_vld",  64'(rd_vld), 64'd1);
                chk("stream_data", rd_data,     base + 64'(k - 3));
            end
            tick();
        end
        wr_vld = 1'b0;
        e = 1997;
        for (int c = 0; c < 10 && e < 2000; c++) begin
            if (rd_vld) begin
                chk("stream_tail", rd_data, base + 64'(e));
                e++;
            end
            tick();
        end
        chk("stream_tail_count", 64'(e), 64'd2000);
        chk("stream_empty", 64'(empty), 64'd1);

        // ---- flush with level 500 and a fetch in flight
        rd_rdy = 1'b0;
        for (int i = 0; i < 503; i++) begin
            wr_vld = 1'b1; wr_data = 64'h7000 + 64'(i);
            tick();
        end
        wr_vld = 1'b0;
        repeat (4) tick();
        chk("fl_level_501", 64'(level), 64'd501);
        chk("fl_rd_data0",  rd_data,    64'h7000);
        rd_rdy = 1'b1;
        tick(); rd_rdy = 1'b0;
        chk("fl_level_500", 64'(level), 64'd500);
        chk("fl_rd_data1",  rd_data,    64'h7001);
        flush = 1'b1; wr_vld = 1'b1; wr_data = 64'hBAD; #1;
        chk("fl_wr_rdy",  64'(wr_rdy),   64'd0);
        chk("fl_wr_a",    64'(ram_wr_a), 64'd0);
        tick(); flush = 1'b0; wr_vld = 1'b0;
        chk("fl_level",  64'(level),      64'd0);
        chk("fl_rd_vld", 64'(rd_vld),     64'd0);
        chk("fl_empty",  64'(empty),      64'd1);
        chk("fl_ovf",    64'(ovf_err),    64'd0);
        chk("fl_addr_a", 64'(ram_addr_a), 64'd0);
        chk("fl_addr_b", 64'(ram_addr_b), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("fl_no_stale", 64'(rd_vld), 64'd0);
        end
        wr_vld = 1'b1; wr_data = 64'hF1;
        tick(); wr_vld = 1'b0;
        tick(); tick();
        chk("fl_new_vld",  64'(rd_vld), 64'd1);
        chk("fl_new_data", rd_data,     64'hF1);
        rd_rdy = 1'b1; tick(); rd_rdy = 1'b0;

        // ---- asynchronous reset mid-stream
        wr_vld = 1'b1; rd_rdy = 1'b1;
        for (int k = 0; k < 10; k++) begin
            wr_data = 64'h9000 + 64'(k);
            tick();
        end
        reset_n = 1'b0; #1;
        chk("ar_level",   64'(level),      64'd0);
        chk("ar_rd_vld",  64'(rd_vld),     64'd0);
        chk("ar_rd_data", rd_data,         64'd0);
        chk("ar_wr_rdy",  64'(wr_rdy),     64'd0);
        chk("ar_wr_a",    64'(ram_wr_a),   64'd0);
        chk("ar_din_a",   ram_din_a,       64'd0);
        chk("ar_addr_a",  64'(ram_addr_a), 64'd0);
        chk("ar_addr_b",  64'(ram_addr_b), 64'd0);
        chk("ar_empty",   64'(empty),      64'd1);
        wr_vld = 1'b0; rd_rdy = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("ar_no_stale", 64'(rd_vld), 64'd0);
        end
        wr_vld = 1'b1; wr_data = 64'hC0DE;
        tick(); wr_vld = 1'b0;
        tick(); tick();
        chk("ar_new_vld",  64'(rd_vld), 64'd1);
        chk("ar_new_data", rd_data,     64'hC0DE);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sdc_buf_ctrl.md
SDC_BUF_CTRL -- requirements
Module: sdc_buf_ctrl

Interface
REQ-001 Parameter DEPTH, default 1041, number of 64-bit words in the attached dual-port block RAM.
REQ-002 Parameter AW, default 11, RAM address width.
REQ-003 Parameter DW, default 64, data width.
REQ-004 clk  in  1  system clock; all logic on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 wr_vld  in  1  producer (SD read path) offers wr_data.
REQ-007 wr_data  in  DW  producer word.
REQ-008 wr_rdy  out  1  buffer accepts a word this cycle.
REQ-009 rd_vld  out  1  rd_data holds a valid word.
REQ-010 rd_data  out  DW  consumer word.
REQ-011 rd_rdy  in  1  consumer takes rd_data this cycle.
REQ-012 flush  in  1  synchronous clear of all buffer state.
REQ-013 level  out  AW  words resident in RAM and not yet fetched (0..DEPTH).
REQ-014 full, empty  out  1 each  level==DEPTH; level==0.
REQ-015 ovf_err  out  1  sticky: wr_vld seen while wr_rdy low and flush low.
REQ-016 ram_addr_a, ram_wr_a, ram_din_a  out  AW/1/DW  RAM port A, write-only use.
REQ-017 ram_addr_b  out  AW  RAM port B read address; ram_wr_b out 1, tied 0; ram_din_b out DW, tied 0.
REQ-018 ram_dout_b  in  DW  RAM port B registered read data, valid 1 cycle after address.

Function
REQ-019 Write accept = wr_vld & wr_rdy; wr_rdy = !full & !flush, registered-state only (no same-cycle fetch credit).
REQ-020 On accept: ram_wr_a=1, ram_addr_a=wr_ptr, ram_din_a=wr_data; wr_ptr advances; level +1.
REQ-021 Pointers wrap DEPTH-1 -> 0; never reach DEPTH.
REQ-022 Output stage = output register plus one skid register; rd_data always driven from the output register.
REQ-023 Fetch issues when level>0 and (held words + in-flight) <2, or <3 when a pop (rd_vld & rd_rdy) occurs this cycle; fetch drives ram_addr_b=rd_ptr, advances rd_ptr, level -1.
REQ-024 At most one fetch per cycle; fetched data captured from ram_dout_b next cycle into output register if empty or popping, else into skid.
REQ-025 Simultaneous accept and fetch: level unchanged.
REQ-026 A word is never fetched in its own write cycle (level counts it from the next cycle), so port A/B same-address collision cannot occur.
REQ-027 Sustained throughput 1 word/cycle with wr_vld and rd_rdy held high.
REQ-028 Latency: word accepted at cycle N into empty buffer with empty output stage -> rd_vld high at cycle N+3 (fetch N+1, capture N+2, visible after edge N+2).
REQ-029 rd_data and rd_vld stable while rd_vld & !rd_rdy.
REQ-030 flush (highest priority, over accept/fetch/pop): pointers=0, level=0, output and skid registers invalid, in-flight fetch discarded, ovf_err=0, effective next edge.
REQ-031 ovf_err sets on wr_vld & !wr_rdy & !flush; clears only on flush or reset; rejected word dropped.

Reset
REQ-032 reset_n low asynchronously forces: wr_ptr=rd_ptr=0, level=0, empty=1, full=0, wr_rdy=0 while asserted then 1, rd_vld=0, rd_data=0, ovf_err=0, ram_wr_a=0, ram_addr_a=ram_addr_b=0, ram_din_a=0, in-flight discarded.
REQ-033 Release of reset_n takes effect on the first rising clk; first write may be accepted that edge.

Verification
REQ-034 Single word: write 64'hA5A5_0000_0000_0001 at cycle 0, rd_rdy=1 -> rd_vld at cycle 3 with that data, level 1 then 0, empty back to 1.
REQ-035 Fill: 1041 writes, rd_rdy=0 -> after fetch of 2 into stage, level=1039; continue to level=1041, full=1, wr_rdy=0; extra wr_vld -> ovf_err=1, word dropped.
REQ-036 Wrap: write 1500 incrementing words 0..1499 with rd_rdy random 50% -> read order exactly 0..1499, addresses wrap 1040->0, no ovf_err.
REQ-037 Streaming: wr_vld=rd_rdy=1 for 2000 cycles -> after latency 3, one pop per cycle, level constant.
REQ-038 Backpressure: rd_rdy low 5 cycles while rd_vld=1 -> rd_data unchanged, skid holds next word, no loss on release.
REQ-039 flush with level=500 and fetch in flight -> next cycle level=0, rd_vld=0, ovf_err=0, stale in-flight data never presented; async reset mid-stream gives same outcome immediately.
